// File: rtl/camera_capture.sv
// Camera capture: turns an 8-bit RGB565 DVP byte stream (vsync/href framing) into
// decimated framebuffer pixel writes, with frame accounting and malformed-line detection.
module camera_capture #(
    parameter int  p_src_width  = 640,
    parameter int  p_src_height = 480,
    parameter int  p_scaler     = 1,
    localparam int c_fb_width   = p_src_width >> p_scaler,
    localparam int c_fb_height  = p_src_height >> p_scaler,
    localparam int c_addrw      = $clog2(c_fb_width * c_fb_height)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_vsync,
    input  logic               i_href,
    input  logic [7:0]         i_data,
    input  logic               i_enable,
    output logic               o_wr_valid,
    output logic [c_addrw-1:0] o_wr_addr,
    output logic [15:0]        o_wr_data,
    output logic [9:0]         o_row,
    output logic [9:0]         o_col,
    output logic               o_frame_done,
    output logic               o_line_err,
    output logic [7:0]         o_frame_cnt
);
    // Two spare bits let x run past the line width so over-long lines stay detectable.
    localparam int              c_cw   = $clog2(p_src_width > p_src_height ? p_src_width : p_src_height) + 2;
    localparam logic [c_cw-1:0] c_w    = c_cw'(p_src_width);
    localparam logic [c_cw-1:0] c_h    = c_cw'(p_src_height);
    localparam logic [c_cw-1:0] c_one  = c_cw'(1);
    localparam logic [c_cw-1:0] c_mask = c_cw'((1 << p_scaler) - 1);

    typedef enum logic [1:0] {
        S_SYNC,
        S_BLANK,
        S_ACTIVE
    } state_t;

    state_t             state;
    logic               vsync_q;
    logic               href_q;
    logic               phase;
    logic [7:0]         pixel_hi;
    logic [c_cw-1:0]    x;
    logic [c_cw-1:0]    y;
    logic [c_addrw-1:0] addr_cnt;

    logic vsync_rise;
    logic vsync_fall;
    logic byte_lo;
    logic keep;

    always_comb begin
        vsync_rise = i_vsync & ~vsync_q;
        vsync_fall = ~i_vsync & vsync_q;
        byte_lo    = i_href & href_q & phase;
        keep       = ((x & c_mask) == '0) && ((y & c_mask) == '0) && (x < c_w) && (y < c_h);
    end

    always_ff @(posedge i_clk) begin
        // NOTE: reset is synchronous and clears every register, the pixel staging byte
        // included, so nothing from an aborted frame can leak into the next capture.
        if (!i_rst_n) begin
            state        <= S_SYNC;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            phase        <= 1'b0;
            pixel_hi     <= '0;
            x            <= '0;
            y            <= '0;
            addr_cnt     <= '0;
            o_wr_valid   <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_row        <= '0;
            o_col        <= '0;
            o_frame_done <= 1'b0;
            o_line_err   <= 1'b0;
            o_frame_cnt  <= '0;
        end else begin
            vsync_q      <= i_vsync;
            href_q       <= i_href;
            // NOTE: strobes default low and are raised further down; with non-blocking
            // assignment the later write wins, which yields clean one-cycle pulses.
            o_wr_valid   <= 1'b0;
            o_frame_done <= 1'b0;

            case (state)
                S_SYNC: begin
                    if (i_vsync) state <= S_BLANK;
                end

                S_BLANK: begin
                    if (vsync_fall) begin
                        if (i_enable) begin
                            state      <= S_ACTIVE;
                            x          <= '0;
                            y          <= '0;
                            phase      <= 1'b0;
                            addr_cnt   <= '0;
                            o_line_err <= 1'b0;
                        end else begin
                            state <= S_SYNC;
                        end
                    end
                end

                S_ACTIVE: begin
                    if (i_href) begin
                        if (byte_lo) begin
                            phase <= 1'b0;
                            if (x != '1) x <= x + c_one;
                            if (keep) begin
                                o_wr_valid <= 1'b1;
                                o_wr_data  <= {pixel_hi, i_data};
                                o_wr_addr  <= addr_cnt;
                                o_row      <= 10'(y >> p_scaler);
                                o_col      <= 10'(x >> p_scaler);
                                addr_cnt   <= addr_cnt + c_addrw'(1);
                            end
                        end else begin
                            pixel_hi <= i_data;
                            phase    <= 1'b1;
                        end
                    end else if (href_q) begin
                        x <= '0;
                        if (y != c_h) y <= y + c_one;
                        if (phase || (x != c_w) || (y >= c_h)) o_line_err <= 1'b1;
                    end

                    // A pixel completing on this same edge has already been issued above.
                    if (vsync_rise) begin
                        state        <= S_BLANK;
                        o_frame_done <= 1'b1;
                        o_frame_cnt  <= o_frame_cnt + 8'd1;
                    end
                end

                default: state <= S_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_camera_capture.sv
// Bench for camera_capture: two instances (decimation 1 and 0) share one randomized DVP
// stream; each frame is checked against a line/pixel-level model of the capture rules.
`timescale 1ns/1ps
module tb_camera_capture;
    localparam int W   = 8;
    localparam int H   = 4;
    localparam int AW1 = $clog2((W >> 1) * (H >> 1));
    localparam int AW0 = $clog2(W * H);

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] data;
        logic [9:0]  row;
        logic [9:0]  col;
    } wr_t;

    logic           i_clk, i_rst_n, i_vsync, i_href, i_enable;
    logic [7:0]     i_data;
    logic           wr_valid1, frame_done1, line_err1;
    logic [AW1-1:0] wr_addr1;
    logic [15:0]    wr_data1;
    logic [9:0]     row1, col1;
    logic [7:0]     frame_cnt1;
    logic           wr_valid0, frame_done0, line_err0;
    logic [AW0-1:0] wr_addr0;
    logic [15:0]    wr_data0;
    logic [9:0]     row0, col0;
    logic [7:0]     frame_cnt0;

    camera_capture #(.p_src_width(W), .p_src_height(H), .p_scaler(1)) dut1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_vsync(i_vsync), .i_href(i_href),
        .i_data(i_data), .i_enable(i_enable), .o_wr_valid(wr_valid1), .o_wr_addr(wr_addr1),
        .o_wr_data(wr_data1), .o_row(row1), .o_col(col1), .o_frame_done(frame_done1),
        .o_line_err(line_err1), .o_frame_cnt(frame_cnt1)
    );

    camera_capture #(.p_src_width(W), .p_src_height(H), .p_scaler(0)) dut0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_vsync(i_vsync), .i_href(i_href),
        .i_data(i_data), .i_enable(i_enable), .o_wr_valid(wr_valid0), .o_wr_addr(wr_addr0),
        .o_wr_data(wr_data0), .o_row(row0), .o_col(col0), .o_frame_done(frame_done0),
        .o_line_err(line_err0), .o_frame_cnt(frame_cnt0)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    wr_t        act1[$], act0[$], exp1[$], exp0[$];
    logic [7:0] fbytes[$];
    int         line_len[$];
    int         done1, done0;
    logic       done_wr1, done_wr0, done_err1, done_err0;
    logic       start_err1, start_err0;
    logic       err_line1[16], err_line0[16];
    logic       exp_err1, exp_err0, exp_lw1, exp_lw0;
    int         exp_cnt;

    // One clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge i_clk);
        #1;
        if (wr_valid1) act1.push_back('{10'(wr_addr1), wr_data1, row1, col1});
        if (wr_valid0) act0.push_back('{10'(wr_addr0), wr_data0, row0, col0});
        if (frame_done1) begin done1++; done_wr1 = wr_valid1; done_err1 = line_err1; end
        if (frame_done0) begin done0++; done_wr0 = wr_valid0; done_err0 = line_err0; end
    endtask

    task automatic set_lines(input int nl, input int len);
        line_len.delete();
        for (int l = 0; l < nl; l++) line_len.push_back(len);
    endtask

    task automatic fill_bytes(input bit seq);
        int total = 0;
        fbytes.delete();
        foreach (line_len[l]) total += line_len[l];
        for (int i = 0; i < total; i++) fbytes.push_back(seq ? 8'(i) : 8'($urandom));
    endtask

    // Reference: walk lines and byte pairs, keep pixels on the decimation grid inside the source.
    task automatic model(input int s, input int n_lines, input bit eob, output logic err, output logic last_wr);
        int  idx, addr, stp, n;
        bit  kp;
        wr_t w;
        idx = 0; addr = 0; stp = 1 << s; err = 1'b0; last_wr = 1'b0;
        if (s == 1) exp1.delete(); else exp0.delete();
        for (int l = 0; l < n_lines; l++) begin
            n = line_len[l];
            for (int px = 0; px < n / 2; px++) begin
                kp = (px < W) && (l < H) && (px % stp == 0) && (l % stp == 0);
                if (kp) begin
                    w.addr = 10'(addr);
                    w.data = {fbytes[idx + 2 * px], fbytes[idx + 2 * px + 1]};
                    w.row  = 10'(l / stp);
                    w.col  = 10'(px / stp);
                    if (s == 1) exp1.push_back(w); else exp0.push_back(w);
                    addr++;
                end
                last_wr = kp;
            end
            if (!(eob && l == n_lines - 1) && ((n % 2 != 0) || (n / 2 != W) || (l >= H))) err = 1'b1;
            idx += n;
        end
    endtask

    task automatic expect_frame(input int n_lines, input bit eob);
        model(1, n_lines, eob, exp_err1, exp_lw1);
        model(0, n_lines, eob, exp_err0, exp_lw0);
        exp_cnt = (exp_cnt + 1) % 256;
    endtask

    function automatic int diff_writes(input int s);
        wr_t a[$], e[$];
        if (s == 1) begin a = act1; e = exp1; end
        else begin a = act0; e = exp0; end
        if (a.size() != e.size()) return -2;
        foreach (e[i])
            if (a[i].addr !== e[i].addr || a[i].data !== e[i].data ||
                a[i].row !== e[i].row || a[i].col !== e[i].col) return i;
        return -1;
    endfunction

    // Frame: blanking, vsync fall, lines separated by idle cycles, vsync rise.
    task automatic drive_frame(input bit en_start, input bit en_mid, input bit eob, input int rst_line);
        int idx = 0;
        int nl  = line_len.size();
        act1.delete(); act0.delete();
        done1 = 0; done0 = 0; done_wr1 = 1'b0; done_wr0 = 1'b0;
        i_vsync = 1'b1; i_href = 1'b0;
        repeat (3) step();
        i_enable = en_start; i_vsync = 1'b0;
        step();
        start_err1 = line_err1; start_err0 = line_err0;
        repeat (2) step();
        for (int l = 0; l < nl; l++) begin
            if (l == 1) i_enable = en_mid;
            for (int b = 0; b < line_len[l]; b++) begin
                i_href = 1'b1; i_data = fbytes[idx]; idx++;
                if (eob && l == nl - 1 && b == line_len[l] - 1) i_vsync = 1'b1;
                if (l == rst_line && b == 0) i_rst_n = 1'b0;
                step();
                i_rst_n = 1'b1;
            end
            if (!(eob && l == nl - 1)) begin
                i_href = 1'b0; i_data = 8'($urandom);
                step();
                err_line1[l] = line_err1; err_line0[l] = line_err0;
                step();
            end
        end
        i_href = 1'b0; i_vsync = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_vsync = 1'($urandom); i_href = 1'($urandom); i_data = 8'($urandom);
            step();
        end
        exp_cnt = 0;
        n_checks++;
        if ({wr_valid1, frame_done1, line_err1} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags1: got %b, required 000", {wr_valid1, frame_done1, line_err1});
        end
        n_checks++;
        if ({wr_valid0, frame_done0, line_err0} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags0: got %b, required 000", {wr_valid0, frame_done0, line_err0});
        end
        n_checks++;
        if ({wr_addr1, wr_data1, row1, col1} !== '0) begin
            n_fail++; $display("FAIL reset_wr1: addr %h data %h row %h col %h, required all 0", wr_addr1, wr_data1, row1, col1);
        end
        n_checks++;
        if ({wr_addr0, wr_data0, row0, col0} !== '0) begin
            n_fail++; $display("FAIL reset_wr0: addr %h data %h row %h col %h, required all 0", wr_addr0, wr_data0, row0, col0);
        end
        n_checks++;
        if ({frame_cnt1, frame_cnt0} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_cnt: got %h/%h, required 00/00", frame_cnt1, frame_cnt0);
        end
        // Out of reset mid-frame: href traffic must not be captured without a vsync sequence.
        i_rst_n = 1'b1; i_vsync = 1'b0;
        act1.delete(); act0.delete();
        for (int i = 0; i < 24; i++) begin
            i_href = (i % 12) < 8; i_data = 8'($urandom);
            step();
        end
        n_checks++;
        if (act1.size() + act0.size() != 0) begin
            n_fail++; $display("FAIL reset_no_capture: got %0d writes, required 0", act1.size() + act0.size());
        end
    endtask

    task automatic test_clean_frame();
        int d;
        set_lines(H, 2 * W); fill_bytes(1'b1);
        drive_frame(1'b1, 1'b1, 1'b0, -1);
        expect_frame(H, 1'b0);
        for (int s = 0; s < 2; s++) begin
            d = diff_writes(s);
            n_checks++;
            if (d != -1) begin
                n_fail++; $display("FAIL clean_writes s=%0d: diff at %0d, got %0d writes, required %0d",
                                   s, d, s ? act1.size() : act0.size(), s ? exp1.size() : exp0.size());
            end
        end
        n_checks++;
        if (act1.size() != 8 || act0.size() != 32) begin
            n_fail++; $display("FAIL clean_counts: got %0d/%0d writes, required 8/32", act1.size(), act0.size());
        end
        n_checks++;
        if (act1.size() == 0 || act1[0].data !== 16'h0001 || act1[0].row !== 10'd0 || act1[0].col !== 10'd0) begin
            n_fail++; $display("FAIL clean_first: got data %h row %0d col %0d, required 0001 row 0 col 0",
                               act1.size() ? act1[0].data : 16'hxxxx, act1.size() ? act1[0].row : 10'd0,
                               act1.size() ? act1[0].col : 10'd0);
        end
        n_checks++;
        if (done1 != 1 || done0 != 1 || frame_cnt1 !== 8'(exp_cnt) || frame_cnt0 !== 8'(exp_cnt)) begin
            n_fail++; $display("FAIL clean_done: done %0d/%0d cnt %0d/%0d, required 1/1 cnt %0d",
                               done1, done0, frame_cnt1, frame_cnt0, exp_cnt);
        end
        n_checks++;
        if ({line_err1, line_err0} !== 2'b00) begin
            n_fail++; $display("FAIL clean_err: got %b, required 00", {line_err1, line_err0});
        end
    endtask

    task automatic test_random_frames();
        int d;
        for (int f = 0; f < 4; f++) begin
            set_lines(H, 2 * W); fill_bytes(1'b0);
            drive_frame(1'b1, 1'($urandom), 1'b0, -1);
            expect_frame(H, 1'b0);
            for (int s = 0; s < 2; s++) begin
                d = diff_writes(s);
                n_checks++;
                if (d != -1) begin
                    n_fail++; $display("FAIL random_writes f=%0d s=%0d: diff at %0d, got %0d writes, required %0d",
                                       f, s, d, s ? act1.size() : act0.size(), s ? exp1.size() : exp0.size());
                end
            end
            n_checks++;
            if (done1 != 1 || done0 != 1 || frame_cnt1 !== 8'(exp_cnt) || frame_cnt0 !== 8'(exp_cnt)) begin
                n_fail++; $display("FAIL random_done f=%0d: done %0d/%0d cnt %0d/%0d, required 1/1 cnt %0d",
                                   f, done1, done0, frame_cnt1, frame_cnt0, exp_cnt);
            end
        end
    endtask

    task automatic test_line_err();
        int d;
        set_lines(H, 2 * W); line_len[1] = 2 * W - 1; fill_bytes(1'b0);
        drive_frame(1'b1, 1'b1, 1'b0, -1);
        expect_frame(H, 1'b0);
        n_checks++;
        if ({err_line1[0], err_line0[0]} !== 2'b00) begin
            n_fail++; $display("FAIL err_line0: got %b, required 00", {err_line1[0], err_line0[0]});
        end
        n_checks++;
        if ({err_line1[1], err_line0[1]} !== {exp_err1, exp_err0} || exp_err1 !== 1'b1) begin
            n_fail++; $display("FAIL err_line1: got %b, required %b", {err_line1[1], err_line0[1]}, {exp_err1, exp_err0});
        end
        n_checks++;
        if ({done_err1, done_err0} !== 2'b11 || done1 != 1) begin
            n_fail++; $display("FAIL err_at_done: got %b (done %0d), required 11 (done 1)", {done_err1, done_err0}, done1);
        end
        for (int s = 0; s < 2; s++) begin
            d = diff_writes(s);
            n_checks++;
            if (d != -1) begin
                n_fail++; $display("FAIL err_writes s=%0d: diff at %0d, got %0d writes, required %0d",
                                   s, d, s ? act1.size() : act0.size(), s ? exp1.size() : exp0.size());
            end
        end
        set_lines(H, 2 * W); fill_bytes(1'b0);
        drive_frame(1'b1, 1'b1, 1'b0, -1);
        expect_frame(H, 1'b0);
        n_checks++;
        if ({start_err1, start_err0, line_err1, line_err0} !== 4'b0000) begin
            n_fail++; $display("FAIL err_cleared: start %b end %b, required 00 00",
                               {start_err1, start_err0}, {line_err1, line_err0});
        end
    endtask

    task automatic test_extra_lines();
        int d;
        set_lines(H + 2, 2 * W); line_len[0] = 2 * W + 4; fill_bytes(1'b0);
        drive_frame(1'b1, 1'b1, 1'b0, -1);
        expect_frame(H + 2, 1'b0);
        for (int s = 0; s < 2; s++) begin
            d = diff_writes(s);
            n_checks++;
            if (d != -1) begin
                n_fail++; $display("FAIL extra_writes s=%0d: diff at %0d, got %0d writes, required %0d",
                                   s, d, s ? act1.size() : act0.size(), s ? exp1.size() : exp0.size());
            end
        end
        n_checks++;
        if ({line_err1, line_err0} !== {exp_err1, exp_err0} || done0 != 1) begin
            n_fail++; $display("FAIL extra_err: got %b done %0d, required %b done 1", {line_err1, line_err0}, done0, {exp_err1, exp_err0});
        end
    endtask

    task automatic test_enable();
        int d;
        set_lines(H, 2 * W); fill_bytes(1'b0);
        drive_frame(1'b0, 1'b1, 1'b0, -1);
        n_checks++;
        if (act1.size() + act0.size() != 0 || done1 + done0 != 0 || frame_cnt1 !== 8'(exp_cnt)) begin
            n_fail++; $display("FAIL enable_off: got %0d writes %0d done cnt %0d, required 0 0 cnt %0d",
                               act1.size() + act0.size(), done1 + done0, frame_cnt1, exp_cnt);
        end
        fill_bytes(1'b0);
        drive_frame(1'b1, 1'b0, 1'b0, -1);
        expect_frame(H, 1'b0);
        for (int s = 0; s < 2; s++) begin
            d = diff_writes(s);
            n_checks++;
            if (d != -1) begin
                n_fail++; $display("FAIL enable_next s=%0d: diff at %0d, got %0d writes, required %0d",
                                   s, d, s ? act1.size() : act0.size(), s ? exp1.size() : exp0.size());
            end
        end
        n_checks++;
        if (done1 != 1 || frame_cnt1 !== 8'(exp_cnt)) begin
            n_fail++; $display("FAIL enable_done: done %0d cnt %0d, required 1 cnt %0d", done1, frame_cnt1, exp_cnt);
        end
    endtask

    task automatic test_mid_reset();
        int d;
        set_lines(H, 2 * W); fill_bytes(1'b0);
        drive_frame(1'b1, 1'b1, 1'b0, 2);
        model(1, 2, 1'b0, exp_err1, exp_lw1);
        model(0, 2, 1'b0, exp_err0, exp_lw0);
        exp_cnt = 0;
        for (int s = 0; s < 2; s++) begin
            d = diff_writes(s);
            n_checks++;
            if (d != -1) begin
                n_fail++; $display("FAIL rst_writes s=%0d: diff at %0d, got %0d writes, required %0d",
                                   s, d, s ? act1.size() : act0.size(), s ? exp1.size() : exp0.size());
            end
        end
        n_checks++;
        if (done1 + done0 != 0 || frame_cnt1 !== 8'd0 || frame_cnt0 !== 8'd0) begin
            n_fail++; $display("FAIL rst_cnt: done %0d cnt %0d/%0d, required 0 cnt 0/0", done1 + done0, frame_cnt1, frame_cnt0);
        end
        fill_bytes(1'b0);
        drive_frame(1'b1, 1'b1, 1'b0, -1);
        expect_frame(H, 1'b0);
        n_checks++;
        if (act1.size() != 8 || diff_writes(1) != -1 || frame_cnt1 !== 8'd1) begin
            n_fail++; $display("FAIL rst_next: got %0d writes cnt %0d, required 8 writes cnt 1", act1.size(), frame_cnt1);
        end
    endtask

    task automatic test_end_on_byte();
        int d;
        set_lines(3, 2 * W); line_len[2] = 10; fill_bytes(1'b0);
        drive_frame(1'b1, 1'b1, 1'b1, -1);
        expect_frame(3, 1'b1);
        for (int s = 0; s < 2; s++) begin
            d = diff_writes(s);
            n_checks++;
            if (d != -1) begin
                n_fail++; $display("FAIL eob_writes s=%0d: diff at %0d, got %0d writes, required %0d",
                                   s, d, s ? act1.size() : act0.size(), s ? exp1.size() : exp0.size());
            end
        end
        n_checks++;
        if (done1 != 1 || done0 != 1 || {done_wr1, done_wr0} !== {exp_lw1, exp_lw0} || exp_lw1 !== 1'b1) begin
            n_fail++; $display("FAIL eob_same_cycle: done %0d/%0d write-with-done %b, required 1/1 %b",
                               done1, done0, {done_wr1, done_wr0}, {exp_lw1, exp_lw0});
        end
        n_checks++;
        if ({line_err1, line_err0} !== {exp_err1, exp_err0} || frame_cnt1 !== 8'(exp_cnt)) begin
            n_fail++; $display("FAIL eob_state: err %b cnt %0d, required %b cnt %0d",
                               {line_err1, line_err0}, frame_cnt1, {exp_err1, exp_err0}, exp_cnt);
        end
    endtask

    task automatic test_idle_href();
        act1.delete(); act0.delete();
        done1 = 0; done0 = 0;
        i_vsync = 1'b1;
        for (int i = 0; i < 20; i++) begin
            i_href = (i % 10) < 6; i_data = 8'($urandom);
            step();
        end
        i_href = 1'b0;
        n_checks++;
        if (act1.size() + act0.size() != 0 || done1 + done0 != 0) begin
            n_fail++; $display("FAIL idle_href: got %0d writes %0d done, required 0 0", act1.size() + act0.size(), done1 + done0);
        end
    endtask

    task automatic test_frame_wrap();
        i_rst_n = 1'b0; step(); i_rst_n = 1'b1;
        exp_cnt = 0;
        for (int f = 0; f < 256; f++) begin
            set_lines(H, 2 * W); fill_bytes(1'b0);
            drive_frame(1'b1, 1'b1, 1'b0, -1);
            expect_frame(H, 1'b0);
            if (f == 254) begin
                n_checks++;
                if (frame_cnt1 !== 8'd255 || frame_cnt0 !== 8'd255) begin
                    n_fail++; $display("FAIL wrap_255: got %0d/%0d, required 255", frame_cnt1, frame_cnt0);
                end
            end
        end
        n_checks++;
        if (frame_cnt1 !== 8'(exp_cnt) || frame_cnt0 !== 8'd0) begin
            n_fail++; $display("FAIL wrap_0: got %0d/%0d, required 0", frame_cnt1, frame_cnt0);
        end
        n_checks++;
        if (diff_writes(1) != -1 || diff_writes(0) != -1) begin
            n_fail++; $display("FAIL wrap_writes: got %0d/%0d writes, required %0d/%0d", act1.size(), act0.size(), exp1.size(), exp0.size());
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst_n = 1'b0; i_vsync = 1'b0; i_href = 1'b0; i_data = 8'h00; i_enable = 1'b0;
        exp_cnt = 0;
        test_reset();
        test_clean_frame();
        test_random_frames();
        test_line_err();
        test_extra_lines();
        test_enable();
        test_mid_reset();
        test_end_on_byte();
        test_idle_href();
        test_frame_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
